uart_rx_control: RTL and testbench
==================================

UART_RX_CONTROL -- requirements
Module: uart_rx_control

Interface
REQ-001 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port RX_IN  input  1  serial line, idle high, already synchronised upstream.
REQ-004 SHALL have port Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-005 SHALL have port Parity_EN  input  1  parity bit present in frame.
REQ-006 SHALL have port Parity_TYPE  input  1  0 = even, 1 = odd.
REQ-007 SHALL have port P_DATA  output  8  last received byte.
REQ-008 SHALL have port Data_valid  output  1  one-cycle pulse; P_DATA holds a good byte.
REQ-009 SHALL have port Parity_error  output  1  one-cycle pulse on parity mismatch.
REQ-010 SHALL have port Stop_error  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 SHALL have port Busy  output  1  high in every state except Idle.

Function
REQ-012 SHALL implement these states: Idle, Start, Data, Parity, Stop.
REQ-013 SHALL use an edge counter of 0..Prescale-1 per bit and a bit counter of 0..7 for data bits.
REQ-014 SHALL take three samples per bit at edge counts Prescale/2-1, Prescale/2 and Prescale/2+1, and SHALL use the majority vote as the bit value.
REQ-015 SHALL treat an illegal Prescale value as 8.
REQ-016 SHALL latch Prescale, Parity_EN and Parity_TYPE on leaving Idle, and SHALL ignore changes to them mid-frame.
REQ-017 Idle -> Start SHALL occur on the first cycle RX_IN is sampled 0.
REQ-018 Start: if the voted bit is 1 (glitch), the block SHALL return to Idle at end of bit with no output pulse; otherwise it SHALL go to Data.
REQ-019 Data SHALL shift in bits LSB first, and SHALL exit after bit 7 to Parity if Parity_EN=1, else to Stop.
REQ-020 Parity SHALL compare the voted bit against the even/odd parity of the 8 data bits.
REQ-021 Stop: at edge count Prescale-1 the block SHALL evaluate the frame:
- no error: P_DATA updates and Data_valid pulses in the same cycle.
- Parity_error and/or Stop_error: the error pulse(s) fire, Data_valid stays 0 and P_DATA is unchanged.
REQ-022 After Stop, the next state SHALL be Start if RX_IN=0 that cycle (back-to-back frame), else Idle.
REQ-023 Frame latency: Data_valid SHALL occur (10 + Parity_EN) × Prescale cycles after the falling start edge is first sampled, ±1 cycle.
REQ-024 P_DATA SHALL hold its value until the next valid frame.
REQ-025 Output pulses SHALL be exactly one cycle wide.

Reset
REQ-026 Reset assertion SHALL immediately force Idle, clear both counters and the shift register, and set P_DATA=0, Data_valid=0, Parity_error=0, Stop_error=0, Busy=0.
REQ-027 Reset mid-frame SHALL discard the partial byte with no pulse; reception SHALL restart only on a new falling edge after release.

Configuration
REQ-028 Macro UART_RX_PARITY_EN SHALL control parity support.
- Defined: Parity state and Parity_error are fully functional.
- Undefined: Parity state, parity logic and the Parity_TYPE latch are removed; Parity_EN and Parity_TYPE are ignored (ports retained); Parity_error is tied 0; frames are always 10 bits.

Structure
REQ-029 Package uart_rx_pkg SHALL hold:
- state encoding constants;
- legal prescale constants (8/16/32);
- data width constant (8).
REQ-030 Edge counter plus three-sample majority voter SHALL be sub-module rx_data_sampler, with outputs sampled_bit and bit_end.

Verification
REQ-031 Prescale=8, Parity_EN=0, frame 0xA5 -> P_DATA=0xA5; Data_valid one pulse at ~80 cycles; no error pulses.
REQ-032 Prescale=16, Parity_EN=1, even, byte 0x3C, parity bit 0 -> Data_valid with P_DATA=0x3C; same frame with parity bit 1 -> Parity_error pulse, P_DATA keeps 0x3C, no Data_valid.
REQ-033 Prescale=32, byte 0x00, stop bit driven 0 -> Stop_error pulse, no Data_valid; next good frame 0xFF -> Data_valid with P_DATA=0xFF.
REQ-034 Prescale=8, RX_IN low for 2 cycles only -> return to Idle after 8 cycles; Busy pulses, no outputs fire.
REQ-035 Two back-to-back frames 0x12 and 0x34 with no idle gap -> two Data_valid pulses, 0x12 then 0x34.
REQ-036 Reset asserted during data bit 4 of a 0x55 frame -> all outputs 0 immediately; no Data_valid for that frame; following frame 0x66 -> Data_valid with P_DATA=0x66.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding,
// the legal oversampling ratios and the payload width.
package uart_rx_pkg;

  localparam int DATA_W = 8;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Any ratio other than 8/16/32 falls back to 8.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
      default:                              return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line, frame configuration and received-byte outputs of the UART receiver.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic              RX_IN;
  logic [5:0]        Prescale;
  logic              Parity_EN;
  logic              Parity_TYPE;
  logic [DATA_W-1:0] P_DATA;
  logic              Data_valid;
  logic              Parity_error;
  logic              Stop_error;
  logic              Busy;

  modport slave (
    input  RX_IN, Prescale, Parity_EN, Parity_TYPE,
    output P_DATA, Data_valid, Parity_error, Stop_error, Busy
  );

  modport master (
    output RX_IN, Prescale, Parity_EN, Parity_TYPE,
    input  P_DATA, Data_valid, Parity_error, Stop_error, Busy
  );

endinterface

// File: rtl/uart_rx_control_sampler.sv
// Per-bit edge counter with three mid-bit samples and a majority vote.
// bit_end is combinational and marks the last edge count of the current bit.
module rx_data_sampler (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_restart,
  input  logic       i_rx,
  input  logic [5:0] i_prescale,
  output logic       sampled_bit,
  output logic       bit_end
);

  logic [5:0] r_edge_cnt;
  logic [2:0] r_samples;
  logic [5:0] w_mid;

  assign w_mid       = {1'b0, i_prescale[5:1]};
  assign bit_end     = i_en && (r_edge_cnt == i_prescale - 6'd1);
  assign sampled_bit = (r_samples[0] & r_samples[1]) |
                       (r_samples[0] & r_samples[2]) |
                       (r_samples[1] & r_samples[2]);

  // The cycle that detects the falling edge is edge 0, so restart loads 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge_cnt <= '0;
      r_samples  <= '0;
    end else begin
      if (i_restart)
        r_edge_cnt <= 6'd1;
      else if (!i_en || bit_end)
        r_edge_cnt <= '0;
      else
        r_edge_cnt <= r_edge_cnt + 6'd1;

      if (i_en) begin
        if (r_edge_cnt == w_mid - 6'd1) r_samples[0] <= i_rx;
        if (r_edge_cnt == w_mid)        r_samples[1] <= i_rx;
        if (r_edge_cnt == w_mid + 6'd1) r_samples[2] <= i_rx;
      end
    end
  end

endmodule

// File: rtl/uart_rx_control.sv
// UART receiver FSM (Idle/Start/Data/Parity/Stop) with registered one-cycle result pulses.
// Parity support is built only when UART_RX_PARITY_EN is defined; otherwise frames are 10 bits.
module uart_rx_control
  import uart_rx_pkg::*;
(
  input logic      CLK,
  input logic      Reset,
  uart_rx_if.slave bus
);

  state_t            r_state;
  logic [5:0]        r_prescale;
  logic [2:0]        r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_p_data;
  logic              r_data_valid;
  logic              r_stop_error;
  logic              r_busy;

  logic              w_sampled_bit;
  logic              w_bit_end;
  logic              w_en;
  logic              w_restart;
  logic              w_parity_bad;

`ifdef UART_RX_PARITY_EN
  logic              r_parity_en;
  logic              r_parity_type;
  logic              r_parity_bad;
  logic              r_parity_error;

  assign w_parity_bad     = r_parity_bad;
  assign bus.Parity_error = r_parity_error;
`else
  logic              w_unused_cfg;

  assign w_unused_cfg     = bus.Parity_EN ^ bus.Parity_TYPE;
  assign w_parity_bad     = 1'b0;
  assign bus.Parity_error = 1'b0;
`endif

  assign w_en      = (r_state != ST_IDLE);
  // A new frame starts from Idle or straight out of Stop when the line is already low.
  assign w_restart = !bus.RX_IN &&
                     ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

  rx_data_sampler u_sampler (
    .clk         (CLK),
    .rst         (Reset),
    .i_en        (w_en),
    .i_restart   (w_restart),
    .i_rx        (bus.RX_IN),
    .i_prescale  (r_prescale),
    .sampled_bit (w_sampled_bit),
    .bit_end     (w_bit_end)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state        <= ST_IDLE;
      r_prescale     <= PRESCALE_8;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_p_data       <= '0;
      r_data_valid   <= 1'b0;
      r_stop_error   <= 1'b0;
      r_busy         <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_en    <= 1'b0;
      r_parity_type  <= 1'b0;
      r_parity_bad   <= 1'b0;
      r_parity_error <= 1'b0;
`endif
    end else begin
      r_data_valid   <= 1'b0;
      r_stop_error   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_error <= 1'b0;
`endif

      if (w_restart) begin
        r_prescale    <= legal_prescale(bus.Prescale);
`ifdef UART_RX_PARITY_EN
        r_parity_en   <= bus.Parity_EN;
        r_parity_type <= bus.Parity_TYPE;
        r_parity_bad  <= 1'b0;
`endif
      end

      case (r_state)
        ST_IDLE: begin
          if (!bus.RX_IN) begin
            r_state <= ST_START;
            r_busy  <= 1'b1;
          end
        end

        ST_START: begin
          if (w_bit_end) begin
            if (w_sampled_bit) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end
        end

        ST_DATA: begin
          if (w_bit_end) begin
            r_shift <= {w_sampled_bit, r_shift[DATA_W-1:1]};
            if (r_bit_cnt == 3'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
              r_state <= r_parity_en ? ST_PARITY : ST_STOP;
`else
              r_state <= ST_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_parity_bad <= (w_sampled_bit != ((^r_shift) ^ r_parity_type));
            r_state      <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (w_bit_end) begin
            r_stop_error <= !w_sampled_bit;
`ifdef UART_RX_PARITY_EN
            r_parity_error <= r_parity_bad;
`endif
            if (w_sampled_bit && !w_parity_bad) begin
              r_p_data     <= r_shift;
              r_data_valid <= 1'b1;
            end
            if (bus.RX_IN) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_START;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.P_DATA     = r_p_data;
  assign bus.Data_valid = r_data_valid;
  assign bus.Stop_error = r_stop_error;
  assign bus.Busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_control.sv
// Directed bench for uart_rx_control: hand-built serial frames, pulse monitor, expected values from the frame tables.
module tb_uart_rx_control;

  logic CLK = 1'b0;
  logic Reset;

  uart_rx_if bus();

  uart_rx_control dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor, sampled on the falling edge.
  int         dv_cnt = 0, pe_cnt = 0, se_cnt = 0, busy_hi = 0, wide_cnt = 0, dv_cyc = 0;
  logic [7:0] dv_log [0:63];
  logic       prev_dv = 1'b0, prev_pe = 1'b0, prev_se = 1'b0;

  always @(negedge CLK) begin
    if (bus.Data_valid === 1'b1) begin
      dv_log[dv_cnt[5:0]] = bus.P_DATA;
      dv_cnt++;
      dv_cyc = cyc;
    end
    if (bus.Parity_error === 1'b1) pe_cnt++;
    if (bus.Stop_error === 1'b1)   se_cnt++;
    if (bus.Busy === 1'b1)         busy_hi++;
    if ((bus.Data_valid === 1'b1 && prev_dv) || (bus.Parity_error === 1'b1 && prev_pe) ||
        (bus.Stop_error === 1'b1 && prev_se))
      wide_cnt++;
    prev_dv = (bus.Data_valid === 1'b1);
    prev_pe = (bus.Parity_error === 1'b1);
    prev_se = (bus.Stop_error === 1'b1);
  end

  int t_start = 0;

  task automatic drive_bit(input logic b, input int n);
    bus.RX_IN = b;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_on, input logic par_bit,
                            input logic stop_bit, input int ps);
    t_start = cyc + 1;
    drive_bit(1'b0, ps);
    for (int i = 0; i < 8; i++) drive_bit(d[i], ps);
    if (par_on) drive_bit(par_bit, ps);
    drive_bit(stop_bit, ps);
  endtask

  // Reports the nominal latency when within +/-1 cycle, otherwise the measured one.
  task automatic check_latency(input string tag, input int nominal);
    int lat;
    lat = dv_cyc - t_start;
    check(tag, (lat >= nominal - 1 && lat <= nominal + 1) ? nominal : lat, nominal);
  endtask

  initial begin
    int b_dv, b_pe, b_se, b_busy, bh;

    bus.RX_IN       = 1'b1;
    bus.Prescale    = 6'd8;
    bus.Parity_EN   = 1'b0;
    bus.Parity_TYPE = 1'b0;
    Reset           = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_pdata", 32'(bus.P_DATA), 32'h0);
    check("rst_dv",    32'(bus.Data_valid), 32'h0);
    check("rst_pe",    32'(bus.Parity_error), 32'h0);
    check("rst_se",    32'(bus.Stop_error), 32'h0);
    check("rst_busy",  32'(bus.Busy), 32'h0);
    Reset = 1'b0;
    idle(5);

    // Prescale 8, 0xA5; config changes mid-frame must be ignored.
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8);
      begin
        repeat (12) @(posedge CLK);
        #1;
        bus.Prescale  = 6'd16;
        bus.Parity_EN = 1'b1;
      end
    join
    idle(4);
    bus.Prescale  = 6'd8;
    bus.Parity_EN = 1'b0;
    check("a5_dv",   dv_cnt - b_dv, 1);
    check("a5_data", 32'(bus.P_DATA), 32'hA5);
    check_latency("a5_lat", 80);
    check("a5_pe",   pe_cnt - b_pe, 0);
    check("a5_se",   se_cnt - b_se, 0);

`ifdef UART_RX_PARITY_EN
    bus.Prescale = 6'd16; bus.Parity_EN = 1'b1; bus.Parity_TYPE = 1'b0;
    b_dv = dv_cnt; b_pe = pe_cnt;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16);
    idle(4);
    check("par_ok_dv",   dv_cnt - b_dv, 1);
    check("par_ok_data", 32'(bus.P_DATA), 32'h3C);
    check_latency("par_ok_lat", 176);
    check("par_ok_pe",   pe_cnt - b_pe, 0);
    b_dv = dv_cnt; b_pe = pe_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
    idle(4);
    check("par_bad_pe",   pe_cnt - b_pe, 1);
    check("par_bad_dv",   dv_cnt - b_dv, 0);
    check("par_bad_hold", 32'(bus.P_DATA), 32'h3C);
    bus.Parity_TYPE = 1'b1;
    b_dv = dv_cnt; b_pe = pe_cnt;
    send_frame(8'h3D, 1'b1, 1'b0, 1'b1, 16);
    idle(4);
    check("par_odd_dv",   dv_cnt - b_dv, 1);
    check("par_odd_data", 32'(bus.P_DATA), 32'h3D);
    check("par_odd_pe",   pe_cnt - b_pe, 0);
`else
    bus.Prescale = 6'd16; bus.Parity_EN = 1'b1; bus.Parity_TYPE = 1'b1;
    b_dv = dv_cnt; b_pe = pe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 16);
    idle(4);
    check("nopar_dv",   dv_cnt - b_dv, 1);
    check("nopar_data", 32'(bus.P_DATA), 32'h3C);
    check_latency("nopar_lat", 160);
    b_dv = dv_cnt;
    send_frame(8'h3D, 1'b0, 1'b0, 1'b1, 16);
    idle(4);
    check("nopar2_dv",   dv_cnt - b_dv, 1);
    check("nopar2_data", 32'(bus.P_DATA), 32'h3D);
    check("nopar_pe",    pe_cnt - b_pe, 0);
`endif
    bus.Parity_EN = 1'b0; bus.Parity_TYPE = 1'b0;

    // Prescale 32: stop bit low, then a good 0xFF.
    bus.Prescale = 6'd32;
    b_dv = dv_cnt; b_se = se_cnt;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 32);
    idle(96);
    check("stop_se", se_cnt - b_se, 1);
    check("stop_dv", dv_cnt - b_dv, 0);
    b_dv = dv_cnt;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 32);
    idle(4);
    check("ff_dv",   dv_cnt - b_dv, 1);
    check("ff_data", 32'(bus.P_DATA), 32'hFF);
    check_latency("ff_lat", 320);

    // Start glitch: two low cycles at prescale 8.
    bus.Prescale = 6'd8;
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt; b_busy = busy_hi;
    drive_bit(1'b0, 2);
    idle(1);
    check("glitch_busy_hi", 32'(bus.Busy), 32'h1);
    idle(9);
    check("glitch_busy_lo", 32'(bus.Busy), 32'h0);
    bh = busy_hi - b_busy;
    check("glitch_busy_len", (bh >= 6 && bh <= 9) ? 8 : bh, 8);
    check("glitch_dv", dv_cnt - b_dv, 0);
    check("glitch_err", (pe_cnt - b_pe) + (se_cnt - b_se), 0);

    // Back-to-back frames, no idle gap.
    bus.Prescale = 6'd16;
    b_dv = dv_cnt; b_se = se_cnt;
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, 16);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1, 16);
    idle(4);
    check("b2b_dv",    dv_cnt - b_dv, 2);
    check("b2b_first", 32'(dv_log[6'(b_dv)]), 32'h12);
    check("b2b_second", 32'(dv_log[6'(b_dv + 1)]), 32'h34);
    check("b2b_se",    se_cnt - b_se, 0);

    // Reset during data bit 4 of 0x55.
    bus.Prescale = 6'd8;
    b_dv = dv_cnt;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(((i % 2) == 0) ? 1'b1 : 1'b0, 8);
    bus.RX_IN = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    Reset = 1'b1;
    #1;
    check("mid_rst_pdata", 32'(bus.P_DATA), 32'h0);
    check("mid_rst_busy",  32'(bus.Busy), 32'h0);
    check("mid_rst_dv",    32'(bus.Data_valid), 32'h0);
    repeat (3) @(posedge CLK);
    #1;
    Reset = 1'b0;
    idle(100);
    check("mid_rst_nopulse", dv_cnt - b_dv, 0);
    send_frame(8'h66, 1'b0, 1'b0, 1'b1, 8);
    idle(4);
    check("post_rst_dv",   dv_cnt - b_dv, 1);
    check("post_rst_data", 32'(bus.P_DATA), 32'h66);

    // Illegal prescale behaves as 8.
    bus.Prescale = 6'd5;
    b_dv = dv_cnt;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8);
    idle(4);
    check("illegal_ps_dv",   dv_cnt - b_dv, 1);
    check("illegal_ps_data", 32'(bus.P_DATA), 32'h5A);

    check("pulse_width", wide_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
